// File: rtl/pong_pkg.sv
// Shared encodings for the pong game controller: FSM state codes and serve directions.
package pong_pkg;

    localparam int unsigned GAME_STATE_W = 3;

    typedef enum logic [GAME_STATE_W-1:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } game_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pong_game_ctrl_tick_gen.sv
// Ball-step prescaler: one-cycle registered strobe every TICK_DIV cycles, held at zero while cleared.
module tick_gen #(
    parameter int unsigned TICK_DIV = 833333
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == CNT_W'(TICK_DIV - 1)) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Game sequencer for ball_movement: serve/play/point/over FSM, scoring, and
// tick-aligned bounce and step strobes.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 833333,
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned SCORE_W     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    paddle_collision,
    input  logic                    wall_collision,
    input  logic                    miss_left,
    input  logic                    miss_right,
    output logic                    move_en,
    output logic                    ball_reset,
    output logic                    bounce_x,
    output logic                    bounce_y,
    output logic                    serve_dir,
    output logic [SCORE_W-1:0]      score_l,
    output logic [SCORE_W-1:0]      score_r,
    output logic [GAME_STATE_W-1:0] game_state,
    output logic                    game_over
);

    localparam int unsigned DLY_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    game_state_t      state;
    logic [DLY_W-1:0] delay_cnt;
    logic             step_pend;
    logic             tick;
    logic             tick_clear;

    assign tick_clear = (state == IDLE) || (state == OVER) || (state == POINT);
    assign game_state = state;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clear(tick_clear),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            delay_cnt  <= '0;
            step_pend  <= 1'b0;
            move_en    <= 1'b0;
            ball_reset <= 1'b1;
            bounce_x   <= 1'b0;
            bounce_y   <= 1'b0;
            serve_dir  <= DIR_RIGHT;
            score_l    <= '0;
            score_r    <= '0;
            game_over  <= 1'b0;
        end else begin
            // Bounce pulses lead the step by one cycle so the reversed direction applies to that step.
            move_en   <= step_pend;
            step_pend <= 1'b0;
            bounce_x  <= 1'b0;
            bounce_y  <= 1'b0;

            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state      <= SERVE;
                        score_l    <= '0;
                        score_r    <= '0;
                        serve_dir  <= DIR_RIGHT;
                        delay_cnt  <= '0;
                        game_over  <= 1'b0;
                        ball_reset <= 1'b1;
                    end
                end
                SERVE: begin
                    if (tick) begin
                        if (delay_cnt == DLY_W'(SERVE_DELAY - 1)) begin
                            delay_cnt  <= '0;
                            state      <= PLAY;
                            ball_reset <= 1'b0;
                        end else begin
                            delay_cnt <= delay_cnt + DLY_W'(1);
                        end
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (miss_left) begin
                            if (score_r != SCORE_W'(WIN_SCORE))
                                score_r <= score_r + SCORE_W'(1);
                            serve_dir  <= DIR_LEFT;
                            state      <= POINT;
                            ball_reset <= 1'b1;
                        end else if (miss_right) begin
                            if (score_l != SCORE_W'(WIN_SCORE))
                                score_l <= score_l + SCORE_W'(1);
                            serve_dir  <= DIR_RIGHT;
                            state      <= POINT;
                            ball_reset <= 1'b1;
                        end else begin
                            bounce_x  <= paddle_collision;
                            bounce_y  <= wall_collision;
                            step_pend <= 1'b1;
                        end
                    end
                end
                POINT: begin
                    delay_cnt <= '0;
                    if (score_l == SCORE_W'(WIN_SCORE) || score_r == SCORE_W'(WIN_SCORE)) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        state <= SERVE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ball_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with TICK_DIV=4, SERVE_DELAY=2, WIN_SCORE=3.
module tb_pong_game_ctrl;

    localparam int unsigned TD = 4;
    localparam int unsigned SD = 2;
    localparam int unsigned WS = 3;
    localparam int unsigned SW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          paddle_collision = 1'b0;
    logic          wall_collision = 1'b0;
    logic          miss_left = 1'b0;
    logic          miss_right = 1'b0;
    logic          move_en, ball_reset, bounce_x, bounce_y, serve_dir, game_over;
    logic [SW-1:0] score_l, score_r;
    logic [2:0]    game_state;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .TICK_DIV(TD),
        .SERVE_DELAY(SD),
        .WIN_SCORE(WS),
        .SCORE_W(SW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .paddle_collision(paddle_collision),
        .wall_collision(wall_collision),
        .miss_left(miss_left),
        .miss_right(miss_right),
        .move_en(move_en),
        .ball_reset(ball_reset),
        .bounce_x(bounce_x),
        .bounce_y(bounce_y),
        .serve_dir(serve_dir),
        .score_l(score_l),
        .score_r(score_r),
        .game_state(game_state),
        .game_over(game_over)
    );

    // Returns the number of cycles until move_en is seen, or -1 after 40 cycles.
    task automatic wait_move(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (move_en === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (game_state !== 3'd0) begin mismatched++; $display("FAIL reset_state: got %0d expected 0", game_state); end
        compared++; if (ball_reset !== 1'b1) begin mismatched++; $display("FAIL reset_ball_reset: got %b expected 1", ball_reset); end
        compared++; if (serve_dir !== 1'b1) begin mismatched++; $display("FAIL reset_serve_dir: got %b expected 1", serve_dir); end
        compared++; if ({move_en, bounce_x, bounce_y, game_over} !== 4'b0000) begin mismatched++; $display("FAIL reset_pulses: got %b expected 0000", {move_en, bounce_x, bounce_y, game_over}); end
        compared++; if ({score_l, score_r} !== 8'h00) begin mismatched++; $display("FAIL reset_scores: got %h expected 00", {score_l, score_r}); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++; if (game_state !== 3'd0) begin mismatched++; $display("FAIL idle_hold: got %0d expected 0", game_state); end
    endtask

    task automatic test_start;
        int n;
        int k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        compared++; if (game_state !== 3'd1) begin mismatched++; $display("FAIL start_state: got %0d expected 1", game_state); end
        compared++; if (ball_reset !== 1'b1) begin mismatched++; $display("FAIL start_ball_reset: got %b expected 1", ball_reset); end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ball_reset === 1'b1) n++;
            else break;
        end
        compared++; if (n < 7 || n > 9) begin mismatched++; $display("FAIL serve_len: got %0d cycles expected 8+-1", n); end
        compared++; if (game_state !== 3'd2) begin mismatched++; $display("FAIL play_entry: got %0d expected 2", game_state); end
        wait_move(k);
        compared++; if (k < 3 || k > 5) begin mismatched++; $display("FAIL first_move: got %0d cycles expected 4+-1", k); end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            compared++; if (move_en !== ((i % 4) == 0)) begin mismatched++; $display("FAIL move_spacing[%0d]: got %b expected %b", i, move_en, (i % 4) == 0); end
            compared++; if ({bounce_x, bounce_y} !== 2'b00) begin mismatched++; $display("FAIL idle_bounce[%0d]: got %b expected 00", i, {bounce_x, bounce_y}); end
        end
    endtask

    // Tick lands two cycles after a move_en; inputs held across it give bounce at +3, step at +4.
    task automatic test_paddle_hit;
        int k;
        wait_move(k);
        compared++; if (k < 0) begin mismatched++; $display("FAIL paddle_sync: got timeout expected move_en"); end
        paddle_collision = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 3) paddle_collision = 1'b0;
            compared++; if (bounce_x !== (i == 3)) begin mismatched++; $display("FAIL paddle_bx[%0d]: got %b expected %b", i, bounce_x, i == 3); end
            compared++; if (bounce_y !== 1'b0) begin mismatched++; $display("FAIL paddle_by[%0d]: got %b expected 0", i, bounce_y); end
            compared++; if (move_en !== (i == 4)) begin mismatched++; $display("FAIL paddle_move[%0d]: got %b expected %b", i, move_en, i == 4); end
        end
    endtask

    task automatic test_off_tick;
        int k;
        wait_move(k);
        compared++; if (k < 0) begin mismatched++; $display("FAIL offtick_sync: got timeout expected move_en"); end
        paddle_collision = 1'b1;
        wall_collision = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin paddle_collision = 1'b0; wall_collision = 1'b0; end
            compared++; if ({bounce_x, bounce_y} !== 2'b00) begin mismatched++; $display("FAIL offtick_bounce[%0d]: got %b expected 00", i, {bounce_x, bounce_y}); end
        end
    endtask

    task automatic test_corner;
        int k;
        wait_move(k);
        compared++; if (k < 0) begin mismatched++; $display("FAIL corner_sync: got timeout expected move_en"); end
        paddle_collision = 1'b1;
        wall_collision = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 3) begin paddle_collision = 1'b0; wall_collision = 1'b0; end
            compared++; if ({bounce_x, bounce_y} !== ((i == 3) ? 2'b11 : 2'b00)) begin mismatched++; $display("FAIL corner_bounce[%0d]: got %b expected %b", i, {bounce_x, bounce_y}, (i == 3) ? 2'b11 : 2'b00); end
            compared++; if (move_en !== (i == 4)) begin mismatched++; $display("FAIL corner_move[%0d]: got %b expected %b", i, move_en, i == 4); end
        end
    endtask

    task automatic test_miss_and_game_end;
        int k;
        for (int p = 0; p < 3; p++) begin
            wait_move(k);
            compared++; if (k < 0) begin mismatched++; $display("FAIL miss_sync[%0d]: got timeout expected move_en", p); end
            miss_right = 1'b1;
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                if (i == 3) begin
                    miss_right = 1'b0;
                    compared++; if (game_state !== 3'd3) begin mismatched++; $display("FAIL miss_point[%0d]: got %0d expected 3", p, game_state); end
                    compared++; if (score_l !== 4'(p + 1) || score_r !== 4'd0) begin mismatched++; $display("FAIL miss_score[%0d]: got l=%0d r=%0d expected l=%0d r=0", p, score_l, score_r, p + 1); end
                    compared++; if ({serve_dir, ball_reset} !== 2'b11) begin mismatched++; $display("FAIL miss_dir_reset[%0d]: got %b expected 11", p, {serve_dir, ball_reset}); end
                end
                if (i == 4) begin
                    compared++; if (game_state !== ((p == 2) ? 3'd4 : 3'd1)) begin mismatched++; $display("FAIL miss_next[%0d]: got %0d expected %0d", p, game_state, (p == 2) ? 4 : 1); end
                    compared++; if ({move_en, game_over} !== {1'b0, p == 2}) begin mismatched++; $display("FAIL miss_move_over[%0d]: got %b expected %b", p, {move_en, game_over}, {1'b0, p == 2}); end
                end
            end
        end
        miss_left = 1'b1;
        repeat (6) @(negedge clk);
        miss_left = 1'b0;
        compared++; if ({game_state, game_over, ball_reset} !== 5'b100_1_1) begin mismatched++; $display("FAIL over_hold: got %b expected 10011", {game_state, game_over, ball_reset}); end
        compared++; if (score_l !== 4'd3 || score_r !== 4'd0) begin mismatched++; $display("FAIL over_frozen: got l=%0d r=%0d expected l=3 r=0", score_l, score_r); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        compared++; if (game_state !== 3'd1 || game_over !== 1'b0) begin mismatched++; $display("FAIL restart_state: got %0d/%b expected 1/0", game_state, game_over); end
        compared++; if ({score_l, score_r} !== 8'h00 || serve_dir !== 1'b1) begin mismatched++; $display("FAIL restart_clear: got %h dir=%b expected 00 dir=1", {score_l, score_r}, serve_dir); end
    endtask

    task automatic test_double_miss;
        int k;
        wait_move(k);
        compared++; if (k < 0) begin mismatched++; $display("FAIL dmiss_sync: got timeout expected move_en"); end
        miss_left = 1'b1;
        miss_right = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 3) begin
                miss_left = 1'b0;
                miss_right = 1'b0;
                compared++; if (score_r !== 4'd1 || score_l !== 4'd0) begin mismatched++; $display("FAIL dmiss_score: got l=%0d r=%0d expected l=0 r=1", score_l, score_r); end
                compared++; if (serve_dir !== 1'b0) begin mismatched++; $display("FAIL dmiss_dir: got %b expected 0", serve_dir); end
            end
            if (i == 4) begin
                compared++; if (game_state !== 3'd1) begin mismatched++; $display("FAIL dmiss_next: got %0d expected 1", game_state); end
            end
        end
    endtask

    task automatic test_reset_mid_play;
        int k;
        wait_move(k);
        compared++; if (k < 0) begin mismatched++; $display("FAIL midrst_sync: got timeout expected move_en"); end
        paddle_collision = 1'b1;
        for (int i = 1; i <= 3; i++) @(negedge clk);
        paddle_collision = 1'b0;
        compared++; if (bounce_x !== 1'b1) begin mismatched++; $display("FAIL midrst_inflight: got %b expected 1", bounce_x); end
        reset = 1'b0;
        #1;
        compared++; if (game_state !== 3'd0 || ball_reset !== 1'b1 || serve_dir !== 1'b1) begin mismatched++; $display("FAIL midrst_async: got st=%0d br=%b dir=%b expected 0/1/1", game_state, ball_reset, serve_dir); end
        compared++; if ({move_en, bounce_x, bounce_y, game_over} !== 4'b0000 || {score_l, score_r} !== 8'h00) begin mismatched++; $display("FAIL midrst_outputs: got %b %h expected 0000 00", {move_en, bounce_x, bounce_y, game_over}, {score_l, score_r}); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            compared++; if (move_en !== 1'b0) begin mismatched++; $display("FAIL midrst_no_move[%0d]: got %b expected 0", i, move_en); end
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compared++; if (game_state !== 3'd0 || move_en !== 1'b0) begin mismatched++; $display("FAIL midrst_idle: got st=%0d move=%b expected 0/0", game_state, move_en); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_paddle_hit();
        test_off_tick();
        test_corner();
        test_miss_and_game_end();
        test_double_miss();
        test_reset_mid_play();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
